mult: RTL and testbench
=======================

MULT -- requirements
Module: mult

Interface
REQ-001 Parameter DATA_SIZE, default 8, operand and result width in bits (signed two's complement).
REQ-002 Parameter FRAC_BITS, default 7, number of fractional bits in the shared fixed-point format (default Q1.7).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair on mult_in_1/mult_in_2 is valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 mult_in_1  input  DATA_SIZE  signed multiplicand.
REQ-008 mult_in_2  input  DATA_SIZE  signed multiplier.
REQ-009 out_valid  output  1  mult_out/ovf hold a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 mult_out  output  DATA_SIZE  signed fixed-point product, same format as the inputs.
REQ-012 ovf  output  1  result was saturated; qualified by out_valid.

Function
REQ-013 Transfer rule: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
REQ-014 Pipeline: 2 stages. Stage 1 registers the full 2*DATA_SIZE signed product; stage 2 registers the rounded, shifted and saturated result. Latency is 2 cycles from acceptance to out_valid with no stall.
REQ-015 Arithmetic: the full product is signed. It is arithmetically shifted right by FRAC_BITS after the rounding step in REQ-024.
REQ-016 Saturation: a shifted value above 2^(DATA_SIZE-1)-1 is clamped to that maximum (127); a value below -2^(DATA_SIZE-1) is clamped to that minimum (-128). ovf is 1 when clamping occurs, 0 otherwise.
REQ-017 Backpressure: when out_valid=1 and out_ready=0, every pipeline stage holds its contents and mult_out/ovf stay stable.
REQ-018 in_ready = !out_valid || out_ready, or stage 1 empty. Throughput is 1 result per cycle when out_ready is held at 1.
REQ-019 Simultaneous accept and consume in the same cycle is legal; no bubble is inserted.
REQ-020 Inputs are ignored while in_valid=0. mult_out holds its last value when out_valid=0.

Reset
REQ-021 While rst=1 on a clock edge: all valid flags clear, mult_out=0, ovf=0, and in_ready=1 in the first cycle after reset.
REQ-022 Reset asserted mid-operation discards all in-flight results; no out_valid is produced for them.

Configuration
REQ-023 Macro MULT_ROUND_EN selects the rounding mode.
REQ-024 With MULT_ROUND_EN defined: 2^(FRAC_BITS-1) is added to the product before the shift (round half toward +inf). Without it: plain arithmetic shift (truncation toward -inf).

Verification
REQ-025 mult_in_1=8'd204 (-52), mult_in_2=8'd80 (80), one beat -> after 2 cycles mult_out=-32 with MULT_ROUND_EN defined, -33 without it; ovf=0 in both cases.
REQ-026 64 x 64 -> mult_out=32, ovf=0 (exact result, identical in both modes).
REQ-027 -128 x -128 -> mult_out=127, ovf=1; 127 x -128 -> mult_out=-127, ovf=0.
REQ-028 Back-to-back beats (1,1),(127,127),(-1,-1) with out_ready=1 -> mult_out 0,126,0 on consecutive cycles with ROUND_EN defined; 0,126,0 without it.
REQ-029 Hold out_ready=0 for 3 cycles with 2 beats in flight -> mult_out stable, in_ready=0, no result lost or duplicated after out_ready returns to 1.
REQ-030 Assert rst with 2 beats in flight -> out_valid=0, mult_out=0, ovf=0 on the next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/mult.sv
// mult: pipelined signed fixed-point multiplier with round/truncate and saturation.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, in_ready  operand handshake (accept on in_valid && in_ready)
//   mult_in_1/2         signed operands, DATA_SIZE bits, FRAC_BITS fractional bits
//   out_valid,out_ready result handshake (consume on out_valid && out_ready)
//   mult_out, ovf       saturated product in the operand format, and clamp flag
//
// Build option: define MULT_ROUND_EN to round half toward +inf before the
// shift; otherwise the shift truncates toward -inf.
module mult #(
    parameter int DATA_SIZE = 8,
    parameter int FRAC_BITS = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_SIZE-1:0] mult_in_1,
    input  logic signed [DATA_SIZE-1:0] mult_in_2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_SIZE-1:0] mult_out,
    output logic                        ovf
);
    localparam int PW = 2 * DATA_SIZE;
    // One extra bit so adding the rounding constant can never wrap.
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] MAXV = (RW'(1) << (DATA_SIZE - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;
`ifdef MULT_ROUND_EN
    localparam logic signed [RW-1:0] RND = (RW'(1) << FRAC_BITS) >> 1;
`else
    localparam logic signed [RW-1:0] RND = '0;
`endif

    logic                        v1_q, v1_d, v2_q, v2_d;
    logic        [PW-1:0]        prod_q, prod_d;
    logic signed [DATA_SIZE-1:0] res_q, res_d;
    logic                        ovf_q, ovf_d;
    logic signed [RW-1:0]        rnd, shifted;
    logic                        adv, ld1, hi, lo;

    always_comb begin
        // Stage 2 may take new data when empty or being consumed; stage 1
        // may additionally fill while stalled if it is currently empty.
        adv      = !v2_q || out_ready;
        in_ready = adv || !v1_q;
        ld1      = in_valid && in_ready;
        // Low PW bits of the product of sign-extended operands are the exact
        // two's-complement product.
        prod_d   = ld1 ? {{DATA_SIZE{mult_in_1[DATA_SIZE-1]}}, mult_in_1} *
                         {{DATA_SIZE{mult_in_2[DATA_SIZE-1]}}, mult_in_2} : prod_q;
        v1_d     = ld1 || (v1_q && !adv);
        v2_d     = adv ? v1_q : v2_q;
        rnd      = $signed({prod_q[PW-1], prod_q}) + RND;
        shifted  = rnd >>> FRAC_BITS;
        hi       = shifted > MAXV;
        lo       = shifted < MINV;
        // The result register only changes when a real product moves in,
        // so mult_out keeps its last value across idle cycles.
        res_d    = (adv && v1_q) ? (hi ? MAXV[DATA_SIZE-1:0] :
                                    lo ? MINV[DATA_SIZE-1:0] :
                                         shifted[DATA_SIZE-1:0]) : res_q;
        ovf_d    = (adv && v1_q) ? (hi || lo) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            prod_q <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            prod_q <= prod_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = v2_q;
    assign mult_out  = res_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mult.sv
// tb_mult: scoreboard bench for mult.
module tb_mult;
    localparam int W = 8;
`ifdef MULT_ROUND_EN
    localparam logic [8:0] E25 = 9'h0E0;
`else
    localparam logic [8:0] E25 = 9'h0DF;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, ovf;
    logic signed [W-1:0] a, b, mult_out;
    int errs = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last_res;
    bit last_stall;
    bit acc;

    always #5 clk = ~clk;

    mult #(.DATA_SIZE(W), .FRAC_BITS(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mult_in_1(a), .mult_in_2(b), .out_valid(out_valid),
        .out_ready(out_ready), .mult_out(mult_out), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input int x, input int y);
        int p;
        int s;
        p = x * y;
`ifdef MULT_ROUND_EN
        p += 64;
`endif
        s = p >>> 7;
        if (s > 127) return 9'h17F;
        if (s < -128) return 9'h180;
        return {1'b0, 8'(s)};
    endfunction

    task automatic step(input bit iv, input int x, input int y, input bit ordy,
                        input logic [8:0] e, output bit accepted);
        @(negedge clk);
        in_valid = iv;
        a = W'(x);
        b = W'(y);
        out_ready = ordy;
        #1;
        if (ordy) check("in_ready_open", {31'd0, in_ready}, 32'd1);
        if (last_stall && out_valid) check("hold_out", {23'd0, ovf, mult_out}, {23'd0, last_res});
        last_stall = out_valid && !out_ready;
        last_res = {ovf, mult_out};
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(e);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else check("result", {23'd0, ovf, mult_out}, {23'd0, exp_q.pop_front()});
        end
    endtask

    task automatic send(input int x, input int y, input bit ordy, input logic [8:0] e);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) step(1'b1, x, y, ordy, e, ok);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        last_stall = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mult_out", {24'd0, mult_out}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        send(-52, 80, 1'b1, E25);
        send(64, 64, 1'b1, 9'h020);
        send(-128, -128, 1'b1, 9'h17F);
        send(127, -128, 1'b1, 9'h081);
        send(1, 1, 1'b1, 9'h000);
        send(127, 127, 1'b1, 9'h07E);
        send(-1, -1, 1'b1, 9'h000);
        repeat (3) step(1'b0, 0, 0, 1'b1, 9'h000, acc);
        check("burst_drained", exp_q.size(), 32'd0);

        send(10, 20, 1'b0, model(10, 20));
        send(-30, 40, 1'b0, model(-30, 40));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5, 5, 1'b0, model(5, 5), acc);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        repeat (4) step(1'b0, 0, 0, 1'b1, 9'h000, acc);
        check("stall_drained", exp_q.size(), 32'd0);

        for (int i = 0; i < 60; i++) begin
            int x, y;
            x = int'($urandom_range(0, 255)) - 128;
            y = int'($urandom_range(0, 255)) - 128;
            step(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)), model(x, y), acc);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 0, 0, 1'b1, 9'h000, acc);
        check("random_drained", exp_q.size(), 32'd0);

        send(100, 100, 1'b0, model(100, 100));
        send(-7, 9, 1'b0, model(-7, 9));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_mult_out", {24'd0, mult_out}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        last_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 0, 1'b1, 9'h000, acc);
            check("no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
